alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_if.sv | 32 +++
 rtl/alu_comb_core.sv | 69 ++++++
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
//   alu_op_t    - 3-bit opcode carried on the control input
//   alu_state_t - sequencer states
//   alu_flags_t - NZCV flag bundle
//   is_shift()  - true for the two shift opcodes
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SLL = 3'd1,
        SRL = 3'd2,
        XOR = 3'd3,
        OR  = 3'd4,
        NOT = 3'd5,
        AND = 3'd6,
        SUB = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    function automatic logic is_shift(input alu_op_t op);
        return (op == SLL) || (op == SRL);
    endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if: operand-side and result-side valid/ready handshake of the ALU.
//   slave  - the ALU: takes in_valid/a/b/control/carryin/set_flags/out_ready,
//            drives in_ready/out_valid/result/n/z/c/v
//   master - the surrounding pipeline, opposite directions
interface alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       control;
    logic             carryin;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             n;
    logic             z;
    logic             c;
    logic             v;

    modport slave (
        input  in_valid, a, b, control, carryin, set_flags, out_ready,
        output in_ready, out_valid, result, n, z, c, v
    );

    modport master (
        output in_valid, a, b, control, carryin, set_flags, out_ready,
        input  in_ready, out_valid, result, n, z, c, v
    );
endinterface

// File: rtl/alu_comb_core.sv
// alu_comb_core: purely combinational result and NZCV for every opcode.
//   a, b     - operands; b is also the unsigned shift count
//   op       - opcode
//   carryin  - carry-in for ADD, not-borrow for SUB
//   r, flags - result and NZCV
//   k        - clamped shift count min(b, WIDTH), reused by the iterative shifter
module alu_comb_core
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int KW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    input  logic             carryin,
    output logic [WIDTH-1:0] r,
    output alu_flags_t       flags,
    output logic [KW-1:0]    k
);

    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   shr;
    logic             c_bit;
    logic             v_bit;

    assign k = (b >= W_VAL) ? KW'(WIDTH) : KW'(b);

    always_comb begin
        bb    = (op == SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, carryin};
        // One guard bit on the outgoing side catches the last bit shifted out;
        // a zero count leaves the guard bit at 0.
        shl   = {1'b0, a} << k;
        shr   = {a, 1'b0} >> k;
        r     = '0;
        c_bit = 1'b0;
        v_bit = 1'b0;
        case (op)
            ADD, SUB: begin
                r     = sum[WIDTH-1:0];
                c_bit = sum[WIDTH];
                v_bit = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            SLL: begin
                r     = shl[WIDTH-1:0];
                c_bit = shl[WIDTH];
            end
            SRL: begin
                r     = shr[WIDTH:1];
                c_bit = shr[0];
            end
            XOR:     r = a ^ b;
            OR:      r = a | b;
            NOT:     r = ~a;
            AND:     r = a & b;
            default: r = '0;
        endcase
        flags.n = r[WIDTH-1];
        flags.z = (r == '0);
        flags.c = c_bit;
        flags.v = v_bit;
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with held NZCV flags.
//   clk, reset - clock and synchronous active-high reset
//   bus        - alu_if slave: operand handshake in, result handshake out
// Single-cycle ops complete one cycle after accept. With SHIFT_ITER=1 a shift
// with a nonzero clamped count k walks one bit per cycle and completes k
// cycles later. A completed result is held until taken; a new op may be
// accepted on the same edge the result is taken.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHIFT_ITER = 1
) (
    input  logic clk,
    input  logic reset,
    alu_if.slave bus
);

    localparam int KW = $clog2(WIDTH + 1);

    alu_state_t       state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    alu_flags_t       flags_reg, flags_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [KW-1:0]    cnt_reg, cnt_next;
    logic             left_reg, left_next;
    logic             setf_reg, setf_next;

    alu_op_t          op_in;
    logic [WIDTH-1:0] core_r;
    alu_flags_t       core_flags;
    logic [KW-1:0]    core_k;
    logic [WIDTH-1:0] step_work;
    logic             step_c;
    logic             in_ready_int;
    logic             accept;
    logic             iter_shift;

    assign op_in = alu_op_t'(bus.control);

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .a       (bus.a),
        .b       (bus.b),
        .op      (op_in),
        .carryin (bus.carryin),
        .r       (core_r),
        .flags   (core_flags),
        .k       (core_k)
    );

    // Taking the held result frees the block on the same edge.
    assign in_ready_int = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
    assign accept       = bus.in_valid && in_ready_int;
    assign iter_shift   = (SHIFT_ITER != 0) && is_shift(op_in) && (core_k != '0);

    // One-bit shift of the working register in the latched direction.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign step_work[gi] = left_reg ? 1'b0 : work_reg[gi+1];
            end else if (gi == WIDTH - 1) begin : g_msb
                assign step_work[gi] = left_reg ? work_reg[gi-1] : 1'b0;
            end else begin : g_mid
                assign step_work[gi] = left_reg ? work_reg[gi-1] : work_reg[gi+1];
            end
        end
    endgenerate
    assign step_c = left_reg ? work_reg[WIDTH-1] : work_reg[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            flags_reg  <= '0;
            work_reg   <= '0;
            cnt_reg    <= '0;
            left_reg   <= 1'b0;
            setf_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            flags_reg  <= flags_next;
            work_reg   <= work_next;
            cnt_reg    <= cnt_next;
            left_reg   <= left_next;
            setf_reg   <= setf_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        flags_next  = flags_reg;
        work_next   = work_reg;
        cnt_next    = cnt_reg;
        left_next   = left_reg;
        setf_next   = setf_reg;

        case (state_reg)
            IDLE: ;
            SHIFT: begin
                work_next = step_work;
                cnt_next  = cnt_reg - KW'(1);
                if (cnt_reg == KW'(1)) begin
                    state_next  = DONE;
                    result_next = step_work;
                    if (setf_reg) begin
                        flags_next.n = step_work[WIDTH-1];
                        flags_next.z = (step_work == '0);
                        flags_next.c = step_c;
                        flags_next.v = 1'b0;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready && !bus.in_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Accept overrides the DONE->IDLE path so back-to-back ops stream.
        if (accept) begin
            setf_next = bus.set_flags;
            left_next = (op_in == SLL);
            work_next = bus.a;
            cnt_next  = core_k;
            if (iter_shift) begin
                state_next = SHIFT;
            end else begin
                state_next  = DONE;
                result_next = core_r;
                if (bus.set_flags) begin
                    flags_next = core_flags;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.n         = flags_reg.n;
    assign bus.z         = flags_reg.z;
    assign bus.c         = flags_reg.c;
    assign bus.v         = flags_reg.v;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    alu_if #(.WIDTH(W)) bus();

    alu_seq #(.WIDTH(W), .SHIFT_ITER(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [7:0] r;
        logic [3:0] f;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] f_model  = 4'b0000;
    int         acc_cyc  = 0;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] flags_now();
        return {bus.n, bus.z, bus.c, bus.v};
    endfunction

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                   input logic cin, input logic sf, input logic [3:0] fp);
        exp_t       e;
        logic [8:0] s;
        logic [7:0] r;
        logic [7:0] bx;
        logic       c;
        logic       v;
        int         k;
        int         ssum;
        r  = 8'h00;
        c  = 1'b0;
        v  = 1'b0;
        bx = b;
        k  = (b > 8'd8) ? 8 : int'(b);
        case (op)
            3'd0, 3'd7: begin
                bx   = (op == 3'd7) ? ~b : b;
                s    = {1'b0, a} + {1'b0, bx} + {8'd0, cin};
                r    = s[7:0];
                c    = s[8];
                ssum = int'($signed(a)) + int'($signed(bx)) + int'(cin);
                v    = (ssum > 127) || (ssum < -128);
            end
            3'd1: begin
                r = a;
                for (int i = 0; i < k; i++) begin c = r[7]; r = {r[6:0], 1'b0}; end
            end
            3'd2: begin
                r = a;
                for (int i = 0; i < k; i++) begin c = r[0]; r = {1'b0, r[7:1]}; end
            end
            3'd3: r = a ^ b;
            3'd4: r = a | b;
            3'd5: r = ~a;
            default: r = a & b;
        endcase
        e.r = r;
        e.f = sf ? {r[7], (r == 8'h00), c, v} : fp;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_const(input logic [7:0] r, input logic [3:0] f);
        exp_t e;
        e.r = r;
        e.f = f;
        exp_q.push_back(e);
        f_model = f;
    endtask

    task automatic push_model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                              input logic cin, input logic sf);
        exp_t e;
        e = model(a, b, op, cin, sf, f_model);
        exp_q.push_back(e);
        f_model = e.f;
    endtask

    // Presents one op and returns one cycle after the accepting edge.
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic cin, input logic sf);
        bus.a = a; bus.b = b; bus.control = op; bus.carryin = cin; bus.set_flags = sf;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && !bus.in_ready; i++) tick();
        if (!bus.in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", bus.in_ready);
        end
        acc_cyc = cyc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        for (int i = 0; i < 40 && !bus.out_valid; i++) tick();
        lat = cyc - acc_cyc;
    endtask

    task automatic test_reset();
        exp_t e;
        bus.in_valid = 0; bus.out_ready = 1; bus.a = 0; bus.b = 0;
        bus.control = 0; bus.carryin = 0; bus.set_flags = 0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        e = '0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
        n_checks++;
        if ({bus.result, flags_now()} !== e) begin
            n_fail++; $display("FAIL reset_state: got r=%h nzcv=%b, required r=00 nzcv=0000", bus.result, flags_now());
        end
        $display("reset: out_valid=%b in_ready=%b r=%h nzcv=%b", bus.out_valid, bus.in_ready, bus.result, flags_now());
    endtask

    task automatic test_add();
        exp_t e;
        int   lat;
        push_const(8'h80, 4'b1001);
        drive_op(8'h7F, 8'h01, 3'd0, 1'b0, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!bus.out_valid || lat != 1) begin n_fail++; $display("FAIL add_latency: got %0d, required 1", lat); end
        n_checks++;
        if ({bus.result, flags_now()} !== e) begin
            n_fail++; $display("FAIL add_value: got r=%h nzcv=%b, required r=%h nzcv=%b", bus.result, flags_now(), e.r, e.f);
        end
        $display("add 7f+01: r=%h nzcv=%b lat=%0d", bus.result, flags_now(), lat);
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: out_valid=%b, required 0", bus.out_valid); end
    endtask

    task automatic test_sub();
        exp_t e;
        int   lat;
        logic [7:0] sa[2] = '{8'h05, 8'h00};
        logic [7:0] sb[2] = '{8'h05, 8'h01};
        logic [7:0] sr[2] = '{8'h00, 8'hFF};
        logic [3:0] sf[2] = '{4'b0110, 4'b1000};
        for (int i = 0; i < 2; i++) begin
            push_const(sr[i], sf[i]);
            drive_op(sa[i], sb[i], 3'd7, 1'b1, 1'b1);
            wait_valid(lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!bus.out_valid || lat != 1) begin n_fail++; $display("FAIL sub_latency: got %0d, required 1", lat); end
            n_checks++;
            if ({bus.result, flags_now()} !== e) begin
                n_fail++; $display("FAIL sub_value: got r=%h nzcv=%b, required r=%h nzcv=%b", bus.result, flags_now(), e.r, e.f);
            end
            $display("sub %h-%h: r=%h nzcv=%b", sa[i], sb[i], bus.result, flags_now());
            tick();
        end
    endtask

    task automatic test_shift();
        exp_t e;
        int   lat;
        push_const(8'h00, 4'b0110);
        drive_op(8'h81, 8'd200, 3'd2, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL srl_busy: cycle +%0d in_ready=%b out_valid=%b, required 0 0", i, bus.in_ready, bus.out_valid);
            end
            tick();
        end
        wait_valid(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!bus.out_valid || lat != 9) begin n_fail++; $display("FAIL srl_latency: got %0d, required 9", lat); end
        n_checks++;
        if ({bus.result, flags_now()} !== e) begin
            n_fail++; $display("FAIL srl_value: got r=%h nzcv=%b, required r=%h nzcv=%b", bus.result, flags_now(), e.r, e.f);
        end
        $display("srl 81>>200: r=%h nzcv=%b lat=%0d", bus.result, flags_now(), lat);
        tick();

        push_const(8'h08, 4'b0000);
        drive_op(8'h81, 8'd3, 3'd1, 1'b0, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!bus.out_valid || lat != 4) begin n_fail++; $display("FAIL sll_latency: got %0d, required 4", lat); end
        n_checks++;
        if ({bus.result, flags_now()} !== e) begin
            n_fail++; $display("FAIL sll_value: got r=%h nzcv=%b, required r=%h nzcv=%b", bus.result, flags_now(), e.r, e.f);
        end
        $display("sll 81<<3: r=%h nzcv=%b lat=%0d", bus.result, flags_now(), lat);
        tick();
    endtask

    task automatic test_hold();
        exp_t e;
        bus.out_ready = 1'b0;
        push_const(8'h31, 4'b0000);
        drive_op(8'h10, 8'h20, 3'd0, 1'b1, 1'b1);
        // The next op waits on the bus while the result is held.
        bus.a = 8'hAA; bus.b = 8'h0F; bus.control = 3'd3; bus.carryin = 1'b0; bus.set_flags = 1'b1;
        bus.in_valid = 1'b1;
        push_const(8'hA5, 4'b1000);
        e = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_hs: out_valid=%b in_ready=%b, required 1 0", bus.out_valid, bus.in_ready);
            end
            n_checks++;
            if ({bus.result, flags_now()} !== e) begin
                n_fail++; $display("FAIL hold_value: got r=%h nzcv=%b, required r=%h nzcv=%b", bus.result, flags_now(), e.r, e.f);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: in_ready=%b, required 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        void'(exp_q.pop_front());
        e = exp_q.pop_front();
        n_checks++;
        if (bus.out_valid !== 1'b1 || {bus.result, flags_now()} !== e) begin
            n_fail++; $display("FAIL hold_next_xor: got v=%b r=%h nzcv=%b, required v=1 r=%h nzcv=%b",
                               bus.out_valid, bus.result, flags_now(), e.r, e.f);
        end
        $display("hold then xor: r=%h nzcv=%b", bus.result, flags_now());
        tick();
    endtask

    task automatic test_reset_mid_shift();
        bus.out_ready = 1'b1;
        drive_op(8'hFF, 8'd5, 3'd1, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midshift_busy: in_ready=%b, required 0", bus.in_ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        f_model = 4'b0000;
        exp_q.delete();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midshift_hs: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.result !== 8'h00 || flags_now() !== 4'b0000) begin
            n_fail++; $display("FAIL midshift_state: got r=%h nzcv=%b, required r=00 nzcv=0000", bus.result, flags_now());
        end
        $display("reset mid-shift: out_valid=%b in_ready=%b r=%h nzcv=%b", bus.out_valid, bus.in_ready, bus.result, flags_now());
        tick();
    endtask

    task automatic test_flags_hold();
        exp_t e;
        int   lat;
        push_const(8'h01, 4'b0010);
        drive_op(8'hFF, 8'h02, 3'd0, 1'b0, 1'b1);
        wait_valid(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!bus.out_valid || {bus.result, flags_now()} !== e) begin
            n_fail++; $display("FAIL flagset_add: got r=%h nzcv=%b, required r=%h nzcv=%b", bus.result, flags_now(), e.r, e.f);
        end
        tick();
        push_const(8'h00, 4'b0010);
        drive_op(8'hF0, 8'h0F, 3'd6, 1'b0, 1'b0);
        wait_valid(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!bus.out_valid || lat != 1) begin n_fail++; $display("FAIL noflag_latency: got %0d, required 1", lat); end
        n_checks++;
        if ({bus.result, flags_now()} !== e) begin
            n_fail++; $display("FAIL noflag_and: got r=%h nzcv=%b, required r=%h nzcv=%b", bus.result, flags_now(), e.r, e.f);
        end
        $display("and f0&0f no-flags: r=%h nzcv=%b", bus.result, flags_now());
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [2:0] ops[8] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rs;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = (ops[i] == 3'd1 || ops[i] == 3'd2) ? 8'h00 : 8'($urandom);
            rc = 1'($urandom);
            rs = (i == 6) ? 1'b1 : 1'($urandom);
            bus.a = ra; bus.b = rb; bus.control = ops[i]; bus.carryin = rc; bus.set_flags = rs;
            bus.in_valid = 1'b1;
            push_model(ra, rb, ops[i], rc, rs);
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: op %0d in_ready=%b, required 1", i, bus.in_ready); end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_valid !== 1'b1 || {bus.result, flags_now()} !== e) begin
                n_fail++; $display("FAIL b2b_value: op %0d ctl=%0d got v=%b r=%h nzcv=%b, required v=1 r=%h nzcv=%b",
                                   i, ops[i], bus.out_valid, bus.result, flags_now(), e.r, e.f);
            end
            $display("b2b op%0d ctl=%0d a=%h b=%h cin=%b sf=%b: r=%h nzcv=%b", i, ops[i], ra, rb, rc, rs, bus.result, flags_now());
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        exp_t       e;
        int         lat;
        int         exp_lat;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] op;
        logic       rc;
        logic       rs;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom);
            ra = 8'($urandom);
            rb = (op == 3'd1 || op == 3'd2) ? 8'($urandom_range(0, 11)) : 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            exp_lat = ((op == 3'd1 || op == 3'd2) && rb != 8'h00) ? 1 + ((rb > 8'd8) ? 8 : int'(rb)) : 1;
            push_model(ra, rb, op, rc, rs);
            drive_op(ra, rb, op, rc, rs);
            wait_valid(lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!bus.out_valid || lat != exp_lat) begin
                n_fail++; $display("FAIL rnd_latency: op %0d ctl=%0d got %0d, required %0d", i, op, lat, exp_lat);
            end
            n_checks++;
            if ({bus.result, flags_now()} !== e) begin
                n_fail++; $display("FAIL rnd_value: op %0d ctl=%0d a=%h b=%h got r=%h nzcv=%b, required r=%h nzcv=%b",
                                   i, op, ra, rb, bus.result, flags_now(), e.r, e.f);
            end
            $display("rnd op%0d ctl=%0d a=%h b=%h cin=%b sf=%b: r=%h nzcv=%b lat=%0d", i, op, ra, rb, rc, rs, bus.result, flags_now(), lat);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_hold();
        test_reset_mid_shift();
        test_flags_hold();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
